pc_unit: RTL

Parametrised program counter for the next-generation CPU fetch stage. It replaces the fixed 32-bit PC register with the following features:
- configurable width, reset vector and increment;
- a start-up state, so the first fetch is clean;
- stall hold;
- prioritised redirects (exception, exception return, branch/jump);
- an exception PC (EPC) register;
- a small circular return-address stack (RAS) for call/return.

The block feeds instruction memory and the IF/ID pipeline register.

---
 rtl/pc_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program counter for the fetch stage: start-up state, stall hold,
// prioritised redirects, exception PC and a circular return-address stack.
module pc_unit #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [31:0]      EXC_VECTOR   = 32'h0000_0180,
   parameter int               INC          = 4,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   input  logic             exc_valid,
   input  logic             eret,
   input  logic             ras_push,
   input  logic             ras_pop,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_seq,
   output logic             fetch_valid,
   output logic [WIDTH-1:0] epc,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_underflow
);

   localparam int               PTR_W      = $clog2(RAS_DEPTH);
   localparam int               CNT_W      = PTR_W + 1;
   localparam logic [WIDTH-1:0] EXC_PC     = WIDTH'(EXC_VECTOR);
   localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(RAS_DEPTH);

   typedef enum logic {START, RUN} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] pc_reg, pc_next;
   logic [WIDTH-1:0] epc_reg, epc_next;
   logic [PTR_W-1:0] top_reg, top_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             uflow_reg, uflow_next;

   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic             ras_we;
   logic [PTR_W-1:0] ras_waddr;

   logic             run;
   logic             seq_path;
   logic             pop_hit;
   logic             pop_miss;
   logic             do_push;

   // FSM state register: START after reset, RUN from the first clean edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= START;
      else        state_reg <= state_next;
   end

   // FSM next state: START lasts exactly one edge, RUN holds until reset
   always_comb begin
      state_next = state_reg;
      if (state_reg == START) state_next = RUN;
   end

   // FSM outputs: fetch address is valid only once running
   always_comb begin
      fetch_valid = 1'b0;
      if (state_reg == RUN) fetch_valid = 1'b1;
   end

   assign run    = (state_reg == RUN);
   assign pc_seq = pc_reg + INC_W;

   // Decode which lowest-priority path (sequential / RAS) is taken this cycle
   always_comb begin
      seq_path = run && !exc_valid && !eret && !redirect_valid && !stall;
      pop_hit  = seq_path && ras_pop && (count_reg != '0);
      pop_miss = seq_path && ras_pop && (count_reg == '0);
      do_push  = seq_path && ras_push;
   end

   // Next PC, EPC and underflow pulse in priority order
   always_comb begin
      pc_next    = pc_reg;
      epc_next   = epc_reg;
      uflow_next = pop_miss;
      if (run) begin
         if (exc_valid) begin
            pc_next  = EXC_PC;
            epc_next = pc_reg;
         end else if (eret) begin
            pc_next = epc_reg & ALIGN_MASK;
         end else if (redirect_valid) begin
            pc_next = redirect_target & ALIGN_MASK;
         end else if (stall) begin
            pc_next = pc_reg;
         end else if (pop_hit) begin
            pc_next = ras_mem[top_reg] & ALIGN_MASK;
         end else begin
            pc_next = pc_seq;
         end
      end
   end

   // RAS pointer/count update; a combined push+pop replaces the top in place
   always_comb begin
      top_next   = top_reg;
      count_next = count_reg;
      ras_we     = 1'b0;
      ras_waddr  = top_reg;
      if (do_push && pop_hit) begin
         ras_we    = 1'b1;
         ras_waddr = top_reg;
      end else if (do_push) begin
         ras_we    = 1'b1;
         ras_waddr = top_reg + PTR_W'(1);
         top_next  = top_reg + PTR_W'(1);
         if (count_reg != CNT_MAX) count_next = count_reg + CNT_W'(1);
      end else if (pop_hit) begin
         top_next   = top_reg - PTR_W'(1);
         count_next = count_reg - CNT_W'(1);
      end
   end

   // Architectural registers; reset also empties the RAS by clearing count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg    <= RESET_VECTOR;
         epc_reg   <= '0;
         top_reg   <= '1;
         count_reg <= '0;
         uflow_reg <= 1'b0;
      end else begin
         pc_reg    <= pc_next;
         epc_reg   <= epc_next;
         top_reg   <= top_next;
         count_reg <= count_next;
         uflow_reg <= uflow_next;
      end
   end

   // RAS storage; writes only happen in RUN so reset needs no gating here
   always_ff @(posedge clk) begin
      if (ras_we) ras_mem[ras_waddr] <= pc_seq;
   end

   assign pc_out        = pc_reg;
   assign epc           = epc_reg;
   assign ras_empty     = (count_reg == '0);
   assign ras_full      = (count_reg == CNT_MAX);
   assign ras_underflow = uflow_reg;

endmodule
